mole_game_ctrl: RTL and testbench



---
 rtl/mole_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Multi-channel reaction-game controller: timed lamp phases, debounced button
// hits, score/miss bookkeeping and a one-hot score LED bank.
module mole_game_ctrl #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 32,
   parameter int ON_CYCLES      = 50000000,
   parameter int OFF_BASE       = 250000000,
   parameter int OFF_STEP       = 50000000,
   parameter int MAX_MISS       = 10,
   parameter int SCORE_W        = 32,
   parameter int LED_N          = 6,
   parameter bit PENALIZE_WRONG = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_CH-1:0]  btn_n,
   input  logic               start_n,
   output logic [NUM_CH-1:0]  lamp,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         miss,
   output logic               in_game,
   output logic               game_over,
   output logic [LED_N-1:0]   score_led
);

   localparam logic [63:0] CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
   localparam logic [63:0] DARK_MAX = 64'(OFF_BASE) + 64'(NUM_CH - 1) * 64'(OFF_STEP);
   localparam int          MW       = (SCORE_W > 32) ? SCORE_W : 32;
   localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);

   if (64'(ON_CYCLES) > CNT_MAX || DARK_MAX > CNT_MAX || ON_CYCLES < 1 || OFF_BASE < 1 ||
       MAX_MISS < 1 || MAX_MISS > 255 - NUM_CH) begin : g_bad_params
      $error("mole_game_ctrl: phase lengths must fit CNT_W and MAX_MISS must be in range");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER} state_t;

   state_t             state_q, state_d;
   logic [NUM_CH:0]    sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
   logic [NUM_CH-1:0]  lit_q, lit_d;
   logic [CNT_W-1:0]   cnt_q [NUM_CH];
   logic [CNT_W-1:0]   cnt_d [NUM_CH];
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         miss_q, miss_d;
   logic [LED_N-1:0]   led_q, led_d;
   logic [NUM_CH:0]    press;
   logic               start_evt;
   logic [4:0]         hits, misses;
   logic [MW-1:0]      score_rem;

   function automatic logic [CNT_W-1:0] dark_last(input int ch);
      return CNT_W'(64'(OFF_BASE) + 64'(ch) * 64'(OFF_STEP) - 64'd1);
   endfunction

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                    input logic [4:0] add);
      logic [SCORE_W+5:0] sum;
      sum = (SCORE_W+6)'(s) + (SCORE_W+6)'(add);
      return (sum[SCORE_W+5:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [7:0] clamp_miss(input logic [7:0] m, input logic [4:0] add);
      logic [8:0] sum;
      sum = {1'b0, m} + 9'(add);
      return (sum >= 9'(MAX_MISS)) ? 8'(MAX_MISS) : sum[7:0];
   endfunction

   // Press = falling edge between history and second synchroniser stage; bit NUM_CH is start.
   assign press     = hist_q & ~sync2_q;
   assign start_evt = press[NUM_CH] | press[0];
   assign score_rem = MW'(score_q) % MW'(LED_N);

   always_comb begin
      sync1_d = {start_n, btn_n};
      sync2_d = sync1_q;
      hist_d  = sync2_q;
      state_d = state_q;
      lit_d   = lit_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      miss_d  = miss_q;
      hits    = '0;
      misses  = '0;
      for (int j = 0; j < LED_N; j++) begin
         led_d[j] = (score_rem == MW'(j));
      end
      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_evt) begin
               state_d = ST_PLAY;
               score_d = '0;
               miss_d  = '0;
               lit_d   = '0;
               for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
            end
         end
         ST_PLAY: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (lit_q[i]) begin
                  // A press on the timeout cycle wins over the miss.
                  if (press[i] || cnt_q[i] == ON_LAST) begin
                     lit_d[i] = 1'b0;
                     cnt_d[i] = '0;
                     if (press[i]) hits = hits + 5'd1;
                     else          misses = misses + 5'd1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end else begin
                  if (press[i] && PENALIZE_WRONG) misses = misses + 5'd1;
                  if (cnt_q[i] == dark_last(i)) begin
                     lit_d[i] = 1'b1;
                     cnt_d[i] = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
            end
            score_d = sat_score(score_q, hits);
            miss_d  = clamp_miss(miss_q, misses);
            if (miss_d >= 8'(MAX_MISS)) begin
               state_d = ST_OVER;
               lit_d   = '0;
               for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sync1_q <= '1;
         sync2_q <= '1;
         hist_q  <= '1;
         lit_q   <= '0;
         cnt_q   <= '{default: '0};
         score_q <= '0;
         miss_q  <= '0;
         led_q   <= LED_N'(1);
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         hist_q  <= hist_d;
         lit_q   <= lit_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         miss_q  <= miss_d;
         led_q   <= led_d;
      end
   end

   assign lamp      = lit_q;
   assign score     = score_q;
   assign miss      = miss_q;
   assign in_game   = (state_q == ST_PLAY);
   assign game_over = (state_q == ST_OVER);
   assign score_led = led_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: three instances (plain, penalising, 2-bit score)
// checked every cycle against a deadline-based game model, plus fixed scenarios.
module tb_mole_game_ctrl;
   localparam int NE = 16384;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [1:0] btn_n   = 2'b11;
   logic       start_n = 1'b1;

   logic [1:0] lamp_w  [3];
   logic [7:0] score_w [3];
   logic [1:0] score2;
   logic [7:0] miss_w  [3];
   logic       ing_w   [3];
   logic       gov_w   [3];
   logic [5:0] led_w   [3];

   always #5 clk = ~clk;

   mole_game_ctrl #(.NUM_CH(2), .CNT_W(8), .ON_CYCLES(4), .OFF_BASE(8), .OFF_STEP(2),
      .MAX_MISS(3), .SCORE_W(8), .LED_N(6), .PENALIZE_WRONG(1'b0)) u0 (
      .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n), .lamp(lamp_w[0]),
      .score(score_w[0]), .miss(miss_w[0]), .in_game(ing_w[0]), .game_over(gov_w[0]),
      .score_led(led_w[0]));

   mole_game_ctrl #(.NUM_CH(2), .CNT_W(8), .ON_CYCLES(4), .OFF_BASE(8), .OFF_STEP(2),
      .MAX_MISS(3), .SCORE_W(8), .LED_N(6), .PENALIZE_WRONG(1'b1)) u1 (
      .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n), .lamp(lamp_w[1]),
      .score(score_w[1]), .miss(miss_w[1]), .in_game(ing_w[1]), .game_over(gov_w[1]),
      .score_led(led_w[1]));

   mole_game_ctrl #(.NUM_CH(2), .CNT_W(8), .ON_CYCLES(4), .OFF_BASE(8), .OFF_STEP(2),
      .MAX_MISS(3), .SCORE_W(2), .LED_N(6), .PENALIZE_WRONG(1'b0)) u2 (
      .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n), .lamp(lamp_w[2]),
      .score(score2), .miss(miss_w[2]), .in_game(ing_w[2]), .game_over(gov_w[2]),
      .score_led(led_w[2]));

   assign score_w[2] = {6'b0, score2};

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Game model: each channel holds a lit flag and the edge number its phase ends.
   function automatic int dark_of(input int ch);
      return 8 + 2 * ch;
   endfunction
   function automatic int smax_of(input int u);
      return (u == 2) ? 3 : 255;
   endfunction

   logic [2:0] smp [NE];
   int         n_edge = 3;
   int         mode    [3];   // 0 idle, 1 play, 2 over
   int         m_score [3];
   int         m_miss  [3];
   int         m_led   [3];
   bit         m_lit   [3][2];
   int         m_end   [3][2];
   bit [2:0]   ev;
   int         hits, misses;

   initial begin
      for (int i = 0; i < NE; i++) smp[i] = 3'b111;
   end

   always begin
      @(posedge clk);
      if (n_edge < NE - 1) n_edge++;
      smp[n_edge] = {start_n, btn_n};
      if (reset) begin
         for (int j = 0; j < 3; j++) smp[n_edge - j] = 3'b111;
         for (int u = 0; u < 3; u++) begin
            mode[u] = 0; m_score[u] = 0; m_miss[u] = 0; m_led[u] = 1;
            for (int ch = 0; ch < 2; ch++) m_lit[u][ch] = 1'b0;
         end
      end else begin
         // Event at edge n: input sampled high at n-3 and low at n-2.
         for (int b = 0; b < 3; b++) ev[b] = smp[n_edge - 3][b] && !smp[n_edge - 2][b];
         for (int u = 0; u < 3; u++) begin
            m_led[u] = 1 << (m_score[u] % 6);
            if (mode[u] != 1) begin
               if (ev[0] || ev[2]) begin
                  mode[u] = 1; m_score[u] = 0; m_miss[u] = 0;
                  for (int ch = 0; ch < 2; ch++) begin
                     m_lit[u][ch] = 1'b0;
                     m_end[u][ch] = n_edge + dark_of(ch);
                  end
               end
            end else begin
               hits = 0; misses = 0;
               for (int ch = 0; ch < 2; ch++) begin
                  if (m_lit[u][ch]) begin
                     if (ev[ch] || n_edge == m_end[u][ch]) begin
                        if (ev[ch]) hits++; else misses++;
                        m_lit[u][ch] = 1'b0;
                        m_end[u][ch] = n_edge + dark_of(ch);
                     end
                  end else begin
                     if (ev[ch] && u == 1) misses++;
                     if (n_edge == m_end[u][ch]) begin
                        m_lit[u][ch] = 1'b1;
                        m_end[u][ch] = n_edge + 4;
                     end
                  end
               end
               m_score[u] = (m_score[u] + hits > smax_of(u)) ? smax_of(u) : m_score[u] + hits;
               m_miss[u]  = (m_miss[u] + misses >= 3) ? 3 : m_miss[u] + misses;
               if (m_miss[u] == 3) begin
                  mode[u] = 2;
                  for (int ch = 0; ch < 2; ch++) m_lit[u][ch] = 1'b0;
               end
            end
         end
      end
      #1;
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("u%0d lamp e%0d", u, n_edge), int'(lamp_w[u]), int'({m_lit[u][1], m_lit[u][0]}));
         chk($sformatf("u%0d score e%0d", u, n_edge), int'(score_w[u]), m_score[u]);
         chk($sformatf("u%0d miss e%0d", u, n_edge), int'(miss_w[u]), m_miss[u]);
         chk($sformatf("u%0d in_game e%0d", u, n_edge), int'(ing_w[u]), int'(mode[u] == 1));
         chk($sformatf("u%0d game_over e%0d", u, n_edge), int'(gov_w[u]), int'(mode[u] == 2));
         chk($sformatf("u%0d score_led e%0d", u, n_edge), int'(led_w[u]), m_led[u]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_rst(input string tag, input int u);
      chk({tag, " lamp"}, int'(lamp_w[u]), 0);
      chk({tag, " score"}, int'(score_w[u]), 0);
      chk({tag, " miss"}, int'(miss_w[u]), 0);
      chk({tag, " in_game"}, int'(ing_w[u]), 0);
      chk({tag, " game_over"}, int'(gov_w[u]), 0);
      chk({tag, " score_led"}, int'(led_w[u]), 1);
   endtask

   initial begin
      cyc(2);
      reset = 1'b0;
      cyc(50);
      for (int u = 0; u < 3; u++) chk_rst($sformatf("idle u%0d", u), u);
      // Start pulse; E denotes the PLAY entry edge (k+2).
      start_n = 1'b0;
      cyc(2); chk("start k+1 in_game", int'(ing_w[0]), 0);
      cyc(1); chk("start k+2 in_game", int'(ing_w[0]), 1);
      start_n = 1'b1;
      cyc(7); chk("E+7 lamp", int'(lamp_w[0]), 0);
      cyc(1); chk("E+8 lamp", int'(lamp_w[0]), 1);
      cyc(1); chk("E+9 lamp", int'(lamp_w[0]), 1);
      cyc(1); chk("E+10 lamp", int'(lamp_w[0]), 3);
      cyc(1); chk("E+11 lamp", int'(lamp_w[0]), 3); chk("E+11 miss", int'(miss_w[0]), 0);
      cyc(1); chk("E+12 lamp", int'(lamp_w[0]), 2); chk("E+12 miss", int'(miss_w[0]), 1);
      cyc(2); chk("E+14 lamp", int'(lamp_w[0]), 0); chk("E+14 miss", int'(miss_w[0]), 2);
      cyc(6); chk("E+20 lamp", int'(lamp_w[0]), 1);
      btn_n = 2'b10;
      cyc(2); chk("E+22 lamp", int'(lamp_w[0]), 1); chk("E+22 score", int'(score_w[0]), 0);
      cyc(1); chk("E+23 lamp", int'(lamp_w[0]), 0); chk("E+23 score", int'(score_w[0]), 1);
              chk("E+23 led", int'(led_w[0]), 1);   chk("E+23 miss", int'(miss_w[0]), 2);
      cyc(1); chk("E+24 led", int'(led_w[0]), 2);   chk("E+24 lamp", int'(lamp_w[0]), 2);
      cyc(4); chk("over game_over", int'(gov_w[0]), 1); chk("over in_game", int'(ing_w[0]), 0);
              chk("over lamp", int'(lamp_w[0]), 0);     chk("over score", int'(score_w[0]), 1);
              chk("over miss", int'(miss_w[0]), 3);
      btn_n = 2'b11;
      cyc(2); btn_n = 2'b10;
      cyc(2); chk("restart k+1 game_over", int'(gov_w[0]), 1);
      cyc(1); chk("E2 in_game", int'(ing_w[0]), 1); chk("E2 score", int'(score_w[0]), 0);
              chk("E2 miss", int'(miss_w[0]), 0);   chk("E2 led", int'(led_w[0]), 2);
      btn_n = 2'b11;
      cyc(1); chk("E2+1 led", int'(led_w[0]), 1);
      cyc(7); chk("E2+8 lamp", int'(lamp_w[0]), 1);
      btn_n = 2'b00;
      cyc(2); chk("E2+10 lamp", int'(lamp_w[0]), 3); chk("E2+10 score", int'(score_w[0]), 0);
      cyc(1); chk("dual hit score", int'(score_w[0]), 2); chk("dual hit lamp", int'(lamp_w[0]), 0);
              chk("dual hit miss", int'(miss_w[0]), 0);
      btn_n = 2'b11;
      cyc(9); chk("E2+20 lamp", int'(lamp_w[0]), 1);
      btn_n = 2'b10;
      cyc(2); chk("E2+22 lamp", int'(lamp_w[0]), 3); chk("E2+22 score", int'(score_w[0]), 2);
      cyc(1); chk("timeout hit score", int'(score_w[0]), 3); chk("timeout hit miss", int'(miss_w[0]), 0);
              chk("timeout hit lamp", int'(lamp_w[0]), 2);
      btn_n = 2'b11;
      cyc(2); chk("E2+25 miss", int'(miss_w[0]), 1); chk("E2+25 lamp", int'(lamp_w[0]), 0);
      cyc(1); btn_n = 2'b01;
      cyc(3); chk("dark press no penalty", int'(miss_w[0]), 1);
              chk("dark press penalty", int'(miss_w[1]), 2);
      btn_n = 2'b11;
      reset = 1'b1;
      cyc(1);
      for (int u = 0; u < 3; u++) chk_rst($sformatf("midgame reset u%0d", u), u);
      reset = 1'b0;
      // Randomised play: buttons toggle, short start pulses, rare resets.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 2; b++) if ($urandom_range(0, 5) == 0) btn_n[b] = ~btn_n[b];
         start_n = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
         reset   = ($urandom_range(0, 700) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
